// File: rtl/wb_regport_arb_pkg.sv
// Shared definitions for the writeback register-port arbiter.
package wb_regport_arb_pkg;

  // Default data width of the regfile write port.
  localparam int XLEN_DEFAULT = 32;

  // Register index width (32 architectural registers).
  localparam int REGIDX_W = 5;

  // Default number of pipeline-owned cycles tolerated while a
  // long-latency result is waiting.
  localparam int STARVE_MAX_DEFAULT = 4;

  // Which source owns the write port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_DIV  = 2'd2,
    GNT_LSU  = 2'd3
  } gnt_src_e;

endpackage

// File: rtl/wbarb_rr2.sv
// Two-way round-robin picker. req[0] is the divider, req[1] the load unit.
// rr_ptr = 0 favours req[0]; after a transfer it points at the other one.
module wbarb_rr2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       xfer,
  output logic [1:0] gnt
);

  logic r_rr_ptr;

  // Grant a lone requester directly; break ties with the pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_rr_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // On a transfer, favour whichever requester did not just win.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr <= 1'b0;
    end else if (xfer) begin
      r_rr_ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/wb_regport_arb.sv
// Writeback register-file port arbiter.
// The in-order pipeline has priority; divider and load unit share the
// remaining slots round-robin via valid/ready. A starvation counter raises
// a one-cycle pipe_hold so a waiting long-latency result always drains.
// Optional feature macro: WBARB_SCOREBOARD_EN (pending-write scoreboard).
//
// Handshake: a long-latency source holds valid and payload stable until
// valid && ready is seen at a rising clk edge; ready is combinational from
// the valid inputs and registered state only, never from payload.
module wb_regport_arb
  import wb_regport_arb_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                pipe_wr_reg,
  input  logic [REGIDX_W-1:0] pipe_wr_regindex,
  input  logic [XLEN-1:0]     pipe_wr_wdata,
  input  logic                div_valid,
  output logic                div_ready,
  input  logic [REGIDX_W-1:0] div_regindex,
  input  logic [XLEN-1:0]     div_wdata,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [REGIDX_W-1:0] lsu_regindex,
  input  logic [XLEN-1:0]     lsu_wdata,
  output logic                pipe_hold,
  output logic                wb2regfile_wr_reg,
  output logic [REGIDX_W-1:0] wb2regfile_wr_regindex,
  output logic [XLEN-1:0]     wb2regfile_wr_wdata
`ifdef WBARB_SCOREBOARD_EN
  ,
  input  logic                sb_alloc,
  input  logic [REGIDX_W-1:0] sb_alloc_index,
  output logic [31:0]         sb_busy
`endif
);

  logic                r_pipe_hold;
  logic [3:0]          r_starve_cnt;
  logic                r_wr_reg;
  logic [REGIDX_W-1:0] r_wr_regindex;
  logic [XLEN-1:0]     r_wr_wdata;

  logic                w_pipe_own;
  logic                w_ll_any;
  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_xfer;
  logic                w_we;
  gnt_src_e            w_src;
  logic [REGIDX_W-1:0] w_sel_idx;
  logic [XLEN-1:0]     w_sel_data;

  // During a hold cycle the pipeline request is ignored.
  assign w_pipe_own = pipe_wr_reg & ~r_pipe_hold;
  assign w_ll_any   = div_valid | lsu_valid;
  assign w_req      = w_pipe_own ? 2'b00 : {lsu_valid, div_valid};

  wbarb_rr2 u_rr2 (
    .clk  (clk),
    .rstn (rstn),
    .req  (w_req),
    .xfer (w_xfer),
    .gnt  (w_gnt)
  );

  assign div_ready = w_gnt[0];
  assign lsu_ready = w_gnt[1];

  // Select the owner of the port and its payload for this cycle.
  always_comb begin
    w_src      = GNT_NONE;
    w_sel_idx  = '0;
    w_sel_data = '0;
    if (w_pipe_own) begin
      w_src      = GNT_PIPE;
      w_sel_idx  = pipe_wr_regindex;
      w_sel_data = pipe_wr_wdata;
    end else if (w_gnt[0]) begin
      w_src      = GNT_DIV;
      w_sel_idx  = div_regindex;
      w_sel_data = div_wdata;
    end else if (w_gnt[1]) begin
      w_src      = GNT_LSU;
      w_sel_idx  = lsu_regindex;
      w_sel_data = lsu_wdata;
    end
  end

  // A grant is only issued to a valid requester, so a grant is a transfer.
  assign w_xfer = (w_src == GNT_DIV) || (w_src == GNT_LSU);

  // x0 writes complete their handshake but never enable the regfile.
  assign w_we = (w_src != GNT_NONE) && (w_sel_idx != '0);

  // Register the winning write; payload is zeroed when nothing is written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_reg      <= 1'b0;
      r_wr_regindex <= '0;
      r_wr_wdata    <= '0;
    end else begin
      r_wr_reg      <= w_we;
      r_wr_regindex <= w_we ? w_sel_idx : '0;
      r_wr_wdata    <= w_we ? w_sel_data : '0;
    end
  end

  // Count pipeline-owned cycles while a long-latency result waits, and
  // raise a single hold cycle once the limit is reached.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_starve_cnt <= 4'd0;
      r_pipe_hold  <= 1'b0;
    end else begin
      if (w_xfer || !w_ll_any) begin
        r_starve_cnt <= 4'd0;
      end else if (w_pipe_own && (r_starve_cnt != 4'(STARVE_MAX))) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
      r_pipe_hold <= !r_pipe_hold && w_ll_any && !w_xfer &&
                     (r_starve_cnt == 4'(STARVE_MAX));
    end
  end

  assign pipe_hold              = r_pipe_hold;
  assign wb2regfile_wr_reg      = r_wr_reg;
  assign wb2regfile_wr_regindex = r_wr_regindex;
  assign wb2regfile_wr_wdata    = r_wr_wdata;

`ifdef WBARB_SCOREBOARD_EN
  logic        r_wr_ll;
  logic [31:0] r_sb_busy;
  logic [31:0] w_sb_set;
  logic [31:0] w_sb_clr;

  // Remember whether the registered write came from a long-latency source.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ll <= 1'b0;
    end else begin
      r_wr_ll <= w_xfer;
    end
  end

  // Allocation sets a bit; a long-latency write leaving the port clears it.
  always_comb begin
    w_sb_set = '0;
    w_sb_clr = '0;
    if (sb_alloc && (sb_alloc_index != '0)) begin
      w_sb_set[sb_alloc_index] = 1'b1;
    end
    if (r_wr_reg && r_wr_ll) begin
      w_sb_clr[r_wr_regindex] = 1'b1;
    end
  end

  // Set wins over a same-cycle clear of the same register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sb_busy <= '0;
    end else begin
      r_sb_busy <= (r_sb_busy & ~w_sb_clr) | w_sb_set;
    end
  end

  assign sb_busy = r_sb_busy;
`endif

endmodule

// File: tb/tb_wb_regport_arb.sv
// Directed bench for wb_regport_arb; scoreboard section needs WBARB_SCOREBOARD_EN.
module tb_wb_regport_arb;

  localparam int XLEN = 32;
  localparam int EW   = 1 + 5 + XLEN;

  // Clock and reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic            pipe_wr_reg = 1'b0;
  logic [4:0]      pipe_wr_regindex = '0;
  logic [XLEN-1:0] pipe_wr_wdata = '0;
  logic            div_valid = 1'b0;
  logic            div_ready;
  logic [4:0]      div_regindex = '0;
  logic [XLEN-1:0] div_wdata = '0;
  logic            lsu_valid = 1'b0;
  logic            lsu_ready;
  logic [4:0]      lsu_regindex = '0;
  logic [XLEN-1:0] lsu_wdata = '0;
  logic            pipe_hold;
  logic            wb_we;
  logic [4:0]      wb_idx;
  logic [XLEN-1:0] wb_data;
`ifdef WBARB_SCOREBOARD_EN
  logic            sb_alloc = 1'b0;
  logic [4:0]      sb_alloc_index = '0;
  logic [31:0]     sb_busy;
`endif

  wb_regport_arb #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .pipe_wr_reg            (pipe_wr_reg),
    .pipe_wr_regindex       (pipe_wr_regindex),
    .pipe_wr_wdata          (pipe_wr_wdata),
    .div_valid              (div_valid),
    .div_ready              (div_ready),
    .div_regindex           (div_regindex),
    .div_wdata              (div_wdata),
    .lsu_valid              (lsu_valid),
    .lsu_ready              (lsu_ready),
    .lsu_regindex           (lsu_regindex),
    .lsu_wdata              (lsu_wdata),
    .pipe_hold              (pipe_hold),
    .wb2regfile_wr_reg      (wb_we),
    .wb2regfile_wr_regindex (wb_idx),
    .wb2regfile_wr_wdata    (wb_data)
`ifdef WBARB_SCOREBOARD_EN
    ,
    .sb_alloc               (sb_alloc),
    .sb_alloc_index         (sb_alloc_index),
    .sb_busy                (sb_busy)
`endif
  );

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic we, input logic [4:0] idx, input logic [XLEN-1:0] data);
    exp_q.push_back({we, idx, data});
  endtask

  // Advance one cycle and compare the registered write against the queue.
  task automatic step(input string tag);
    logic [EW-1:0] e;
    @(posedge clk);
    @(negedge clk);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk(tag, {wb_we, wb_idx, wb_data}, e);
  endtask

  // Driver tasks
  task automatic set_pipe(input logic v, input logic [4:0] idx, input logic [XLEN-1:0] d);
    pipe_wr_reg = v; pipe_wr_regindex = idx; pipe_wr_wdata = d;
  endtask
  task automatic set_div(input logic v, input logic [4:0] idx, input logic [XLEN-1:0] d);
    div_valid = v; div_regindex = idx; div_wdata = d;
  endtask
  task automatic set_lsu(input logic v, input logic [4:0] idx, input logic [XLEN-1:0] d);
    lsu_valid = v; lsu_regindex = idx; lsu_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_we", wb_we, 0);
    chk("rst_out", {wb_idx, wb_data}, 0);
    chk("rst_hold", pipe_hold, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Pipe only
    set_pipe(1, 5'd5, 32'h1234); #1;
    chk("pipe_div_rdy", div_ready, 0);
    chk("pipe_lsu_rdy", lsu_ready, 0);
    push_exp(1, 5'd5, 32'h1234);
    step("pipe_wr");
    chk("pipe_no_hold", pipe_hold, 0);
    set_pipe(0, 0, 0); push_exp(0, 0, 0);
    step("pipe_idle");

    // Both long-latency valid, pipe idle
    set_div(1, 5'd3, 32'hAAAA); set_lsu(1, 5'd4, 32'hBBBB); #1;
    chk("tie1_div_rdy", div_ready, 1);
    chk("tie1_lsu_rdy", lsu_ready, 0);
    push_exp(1, 5'd3, 32'hAAAA);
    step("tie1_div_wr");
    set_div(0, 0, 0); #1;
    chk("tie1_lsu_rdy2", lsu_ready, 1);
    push_exp(1, 5'd4, 32'hBBBB);
    step("tie1_lsu_wr");
    set_div(1, 5'd10, 32'h1010); set_lsu(1, 5'd11, 32'h1111); #1;
    chk("tie2_div_rdy", div_ready, 1);
    chk("tie2_lsu_rdy", lsu_ready, 0);
    push_exp(1, 5'd10, 32'h1010);
    step("tie2_div_wr");
    set_div(0, 0, 0); push_exp(1, 5'd11, 32'h1111);
    step("tie2_lsu_wr");
    set_lsu(0, 0, 0); push_exp(0, 0, 0);
    step("tie_idle");

    // Starvation: pipe writes every cycle, lsu waits from cycle 0
    set_lsu(1, 5'd7, 32'h77);
    for (int c = 0; c < 5; c++) begin
      set_pipe(1, 5'(c + 1), 32'h100 + c); #1;
      chk($sformatf("starve_hold_c%0d", c), pipe_hold, 0);
      chk($sformatf("starve_lsu_rdy_c%0d", c), lsu_ready, 0);
      push_exp(1, 5'(c + 1), 32'h100 + c);
      step($sformatf("starve_pipe_wr_c%0d", c));
    end
    set_pipe(1, 5'd6, 32'h105); #1;
    chk("starve_hold_c5", pipe_hold, 1);
    chk("starve_lsu_rdy_c5", lsu_ready, 1);
    push_exp(1, 5'd7, 32'h77);
    step("starve_lsu_wr");
    set_lsu(0, 0, 0); #1;
    chk("starve_hold_c6", pipe_hold, 0);
    push_exp(1, 5'd6, 32'h105);
    step("starve_pipe_represent");
    set_pipe(0, 0, 0); push_exp(0, 0, 0);
    step("starve_idle");

    // x0 write handshakes but does not enable the regfile
    set_div(1, 5'd0, 32'hDEAD); #1;
    chk("x0_div_rdy", div_ready, 1);
    push_exp(0, 0, 0);
    step("x0_wr");
    set_div(0, 0, 0); push_exp(0, 0, 0);
    step("x0_idle");

    // Asynchronous reset while a write is registered
    set_pipe(1, 5'd12, 32'hC0C0);
    @(posedge clk); #2;
    chk("mid_wr_before", {wb_we, wb_idx, wb_data}, {1'b1, 5'd12, 32'hC0C0});
    rstn = 1'b0; #1;
    chk("mid_rst_out", {wb_we, wb_idx, wb_data}, 0);
    chk("mid_rst_hold", pipe_hold, 0);
    set_pipe(0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    set_div(1, 5'd13, 32'hD13); set_lsu(1, 5'd14, 32'hE14); #1;
    chk("post_rst_div_rdy", div_ready, 1);
    chk("post_rst_lsu_rdy", lsu_ready, 0);
    push_exp(1, 5'd13, 32'hD13);
    step("post_rst_div_wr");
    set_div(0, 0, 0); push_exp(1, 5'd14, 32'hE14);
    step("post_rst_lsu_wr");
    set_lsu(0, 0, 0); push_exp(0, 0, 0);
    step("post_rst_idle");

`ifdef WBARB_SCOREBOARD_EN
    // Scoreboard set/clear behaviour
    chk("sb_reset", sb_busy, 0);
    sb_alloc = 1; sb_alloc_index = 5'd9; push_exp(0, 0, 0);
    step("sb_alloc_cyc");
    chk("sb_set9", sb_busy, 32'h200);
    sb_alloc_index = 5'd0; push_exp(0, 0, 0);
    step("sb_alloc0_cyc");
    chk("sb_x0_ignored", sb_busy, 32'h200);
    sb_alloc = 0;
    set_lsu(1, 5'd9, 32'h99); push_exp(1, 5'd9, 32'h99);
    step("sb_lsu_wr1");
    set_lsu(0, 0, 0);
    sb_alloc = 1; sb_alloc_index = 5'd9; push_exp(0, 0, 0);
    step("sb_realloc_cyc");
    sb_alloc = 0;
    chk("sb_set_wins", sb_busy, 32'h200);
    set_pipe(1, 5'd9, 32'h5A5A); push_exp(1, 5'd9, 32'h5A5A);
    step("sb_pipe_wr");
    set_pipe(0, 0, 0); push_exp(0, 0, 0);
    step("sb_pipe_leave");
    chk("sb_pipe_no_clr", sb_busy, 32'h200);
    set_lsu(1, 5'd9, 32'h98); push_exp(1, 5'd9, 32'h98);
    step("sb_lsu_wr2");
    set_lsu(0, 0, 0); push_exp(0, 0, 0);
    step("sb_lsu_leave");
    chk("sb_cleared", sb_busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_regport_arb.md
Name: wb_regport_arb

Overview:
- Controller for the register-file write port fed by the writeback stage.
- Shares the single port between three sources:
  - the in-order pipeline writeback, which has priority;
  - two long-latency producers (divider, load unit) using valid/ready.
- Includes an anti-starvation hold toward the pipeline.
- Registers the winning write into the regfile write interface.

Parameters:
- XLEN, 32, data width of write data.
- STARVE_MAX, 4, consecutive pipeline-owned cycles with a long-latency request pending before pipe_hold is raised; range 1..15.

Ports:
- clk  input  1  core clock
- rstn  input  1  asynchronous active-low reset
- pipe_wr_reg  input  1  pipeline WB write request
- pipe_wr_regindex  input  5  pipeline destination register
- pipe_wr_wdata  input  XLEN  pipeline write data
- div_valid  input  1  divider result valid
- div_ready  output  1  divider result accepted
- div_regindex  input  5  divider destination
- div_wdata  input  XLEN  divider result
- lsu_valid  input  1  load result valid
- lsu_ready  output  1  load result accepted
- lsu_regindex  input  5  load destination
- lsu_wdata  input  XLEN  load data
- pipe_hold  output  1  freeze WB stage one cycle; pipeline re-presents its write next cycle
- wb2regfile_wr_reg  output  1  regfile write enable
- wb2regfile_wr_regindex  output  5  regfile write index
- wb2regfile_wr_wdata  output  XLEN  regfile write data
- sb_alloc  input  1  (WBARB_SCOREBOARD_EN only) issue allocates long-latency destination
- sb_alloc_index  input  5  (WBARB_SCOREBOARD_EN only) allocated register
- sb_busy  output  32  (WBARB_SCOREBOARD_EN only) pending-write bit per register

Behaviour:
- Clocking and reset:
  - Single clock clk; reset rstn is asynchronous and active-low.
  - On reset: wb2regfile_* = 0, pipe_hold = 0, starve_cnt = 0, rr_ptr = 0 (div favoured), sb_busy = 0.
- Port ownership, cycle N:
  - pipe_wr_reg=1 and pipe_hold=0: pipeline owns the port; div_ready = lsu_ready = 0.
  - Otherwise: one long-latency requester is granted. If only one is valid, it wins; if both are valid, rr_ptr decides. Only the winner's ready goes high.
  - During a pipe_hold cycle, pipe_wr_reg is ignored.
- Handshake:
  - ready is combinational from the valid inputs and registered state.
  - A transfer occurs on valid && ready.
  - Sources hold valid and payload stable until the transfer; ready never depends on the same source's payload.
- rr_ptr: updates only on a transfer, and then points to the other requester.
- Output latency: the winning write appears on wb2regfile_* at cycle N+1 for one cycle. wr_reg = 0 when no source wins.
- x0: a write with index 0 completes its handshake but drives wb2regfile_wr_reg = 0.
- starve_cnt (4 bits):
  - Increments when the pipeline owns the port while div_valid | lsu_valid.
  - Clears on any long-latency transfer, or when no long-latency request is valid.
  - Saturates at STARVE_MAX.
- pipe_hold:
  - Registered; goes to 1 in the cycle after starve_cnt reaches STARVE_MAX with a request still valid.
  - Stays 1 for exactly one cycle, then starve_cnt clears.
  - A hold cycle always yields a long-latency grant, because a requester cannot drop valid.
- Same destination index from pipeline and a long-latency source in one cycle: the pipeline wins and the long-latency source waits. WAW ordering is the issue stage's responsibility.
- Reset mid-transfer: the in-flight registered write is dropped. Sources reset together and re-present.

Optional Feature:
- Macro: WBARB_SCOREBOARD_EN.
- Defined:
  - sb_alloc sets sb_busy[sb_alloc_index], except for index 0.
  - A long-latency write leaving on wb2regfile_* clears its bit.
  - Simultaneous set and clear of the same index: set wins.
  - Pipeline writes never clear bits.
- Undefined: sb_alloc, sb_alloc_index and sb_busy ports are absent; no scoreboard flops.

Decomposition:
- Shared package:
  - XLEN;
  - the REGIDX_W = 5 constant;
  - the grant-source enum (GNT_NONE, GNT_PIPE, GNT_DIV, GNT_LSU);
  - the STARVE_MAX default.
- One natural sub-module, wbarb_rr2: a 2-way round-robin picker holding rr_ptr, with inputs req[1:0] and xfer, and output gnt[1:0].

Test Plan:
- Pipe only: pipe_wr_reg=1, idx 5, data 0x1234 at cycle N → wr_reg=1, idx 5, data 0x1234 at N+1; no hold.
- Both long-latency valid, pipe idle:
  - div idx 3 / 0xAAAA and lsu idx 4 / 0xBBBB → div written at N+1, lsu at N+2.
  - rr_ptr then favours div again on the next tie.
- Starvation:
  - pipe writes every cycle; lsu_valid idx 7 / 0x77 held from cycle 0.
  - → pipe_hold=1 at cycle STARVE_MAX+1 (5); lsu_ready=1 that cycle; x7 = 0x77 written the following cycle; pipe_hold=0 afterwards.
- x0: div_valid with idx 0 → div_ready=1, wb2regfile_wr_reg stays 0.
- Reset mid-operation: assert rstn=0 asynchronously while a write is registered → outputs 0 immediately; rr_ptr = div after release.
- Scoreboard (macro on):
  - sb_alloc idx 9 → sb_busy[9]=1 next cycle.
  - Load write to x9 with a same-cycle re-alloc of 9 → bit stays 1.
  - Without the re-alloc → bit clears.
